port_cam_cfg_ctrl: RTL

- Configuration controller for the per-ID destination-port CAM in the NMU ingress parser chain.
- Accepts staged per-ID writes of port value and must-match flag into a shadow bank.
- On a commit request, copies the shadow bank to the active bank, which drives the CAM `ports` / `port_cam_must_match` inputs. The copy happens only at a packet boundary, so no packet is ever matched against half-old, half-new contents.
- Monitors the same AXI stream the CAM parser sees.

---
 rtl/port_cam_cfg_ctrl.sv | 75 +++++++
 1 files changed

// File: rtl/port_cam_cfg_ctrl.sv
// port_cam_cfg_ctrl: shadow/active port CAM config bank with packet-boundary commit
module port_cam_cfg_ctrl #(
  parameter int AXIS_ID_WIDTH = 4,
  parameter int PORT_WIDTH    = 16,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     cfg_wr_valid,
  output logic                     cfg_wr_ready,
  input  logic [AXIS_ID_WIDTH-1:0] cfg_wr_index,
  input  logic [PORT_WIDTH-1:0]    cfg_wr_port,
  input  logic                     cfg_wr_must_match,
  input  logic                     cfg_commit_valid,
  output logic                     cfg_commit_ready,
  output logic                     cfg_commit_done,
  output logic                     cfg_busy,
  input  logic                     mon_tvalid,
  input  logic                     mon_tready,
  input  logic                     mon_tlast,
  output logic [PORT_WIDTH-1:0]    ports [2**AXIS_ID_WIDTH],
  output logic                     port_cam_must_match [2**AXIS_ID_WIDTH],
  output logic [COUNT_WIDTH-1:0]   commit_count
);
  typedef enum logic {IDLE, PENDING} state_t;
  state_t state, state_nx;
  logic [PORT_WIDTH-1:0] shadow_port [2**AXIS_ID_WIDTH];
  logic                  shadow_mm   [2**AXIS_ID_WIDTH];
  logic in_packet, beat, last, boundary, copy;
  assign beat     = mon_tvalid & mon_tready;
  assign last     = beat & mon_tlast;
  assign boundary = last | (!in_packet & !beat);
  assign copy     = (state == PENDING) & boundary;
  // state register
  always_ff @(posedge aclk)
    state <= areset ? IDLE : state_nx;
  // next state: commit handshake arms, first packet boundary completes
  always_comb
    state_nx = (state == IDLE) ? ((cfg_commit_valid) ? PENDING : IDLE) : (boundary ? IDLE : PENDING);
  // handshake outputs decode state
  always_comb begin
    cfg_wr_ready     = (state == IDLE);
    cfg_commit_ready = (state == IDLE);
    cfg_busy         = (state == PENDING);
  end
  // track whether the monitored stream is mid-packet
  always_ff @(posedge aclk)
    if (areset) in_packet <= 1'b0;
    else if (last) in_packet <= 1'b0;
    else if (beat) in_packet <= 1'b1;
  // staged writes land in the shadow bank only
  always_ff @(posedge aclk)
    if (areset) begin
      shadow_port <= '{default: '0};
      shadow_mm   <= '{default: 1'b0};
    end else if (cfg_wr_valid & cfg_wr_ready) begin
      shadow_port[cfg_wr_index] <= cfg_wr_port;
      shadow_mm[cfg_wr_index]   <= cfg_wr_must_match;
    end
  // whole-bank copy at the boundary edge, with done pulse and commit count
  always_ff @(posedge aclk)
    if (areset) begin
      ports               <= '{default: '0};
      port_cam_must_match <= '{default: 1'b0};
      cfg_commit_done     <= 1'b0;
      commit_count        <= '0;
    end else begin
      cfg_commit_done <= copy;
      if (copy) begin
        ports               <= shadow_port;
        port_cam_must_match <= shadow_mm;
        commit_count        <= commit_count + COUNT_WIDTH'(1);
      end
    end
endmodule
